// File: rtl/conv_fc_stream_acc.sv
// Streaming KxK convolution feeding a fully-connected layer, one pixel per transfer.
// Optional build macro CONV_RELU_EN clamps negative conv results to zero before the FC stage.
module conv_fc_stream_acc #(
    parameter int IMG_W = 28,
    parameter int K     = 3,
    parameter int NCLS  = 10,
    parameter int DW    = 8,
    parameter int ACCW  = 32
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic                                             i_pix_valid,
    output logic                                             o_pix_ready,
    input  logic [DW-1:0]                                    i_pix,
    input  logic [K*K*DW-1:0]                                i_conv_weight,
    input  logic [DW-1:0]                                    i_conv_bias,
    input  logic [(IMG_W-K+1)*(IMG_W-K+1)*NCLS*DW-1:0]       i_fc_weight,
    input  logic [NCLS*DW-1:0]                               i_fc_bias,
    output logic                                             o_res_valid,
    input  logic                                             i_res_ready,
    output logic [NCLS*ACCW-1:0]                             o_res
);

    localparam int OW   = IMG_W - K + 1;
    localparam int NPOS = OW * OW;
    localparam int CW   = $clog2(IMG_W);
    localparam int PW   = $clog2(NPOS);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_OUT} state_e;

    state_e                 state_q, state_d;
    logic                   drain_q, drain_d;
    logic                   pix_ready_q, res_valid_q;
    logic [CW-1:0]          col_q, col_d, row_q, row_d;
    logic                   xfer, last_pix, in_win, clear;

    logic [DW-1:0]          lb_q  [K-1][IMG_W];
    logic [DW-1:0]          win_q [K][K];
    logic [DW-1:0]          win_d [K][K];
    logic [DW-1:0]          colv  [K];

    logic signed [ACCW-1:0] conv_d, conv_act, conv_q;
    logic signed [ACCW-1:0] pix_ext, cw_ext;
    logic [PW-1:0]          pos_d, pos_q;
    logic                   tok1_q;

    logic signed [ACCW-1:0] fcw_ext [NCLS];
    logic signed [ACCW-1:0] acc_q   [NCLS];
    logic signed [ACCW-1:0] acc_d   [NCLS];
    logic signed [ACCW-1:0] res_q   [NCLS];

    assign o_pix_ready = pix_ready_q;
    assign o_res_valid = res_valid_q;

    always_comb begin
        xfer     = i_pix_valid & pix_ready_q;
        last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == CW'(IMG_W - 1));
        in_win   = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
        pos_d    = PW'((int'(row_q) - (K - 1)) * OW + int'(col_q) - (K - 1));
    end

    // Column vector for the current pixel: oldest buffered row on top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            colv[r] = lb_q[r][col_q];
        end
        colv[K-1] = i_pix;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = colv[r];
        end
    end

    // Conv uses the window that already includes the pixel being accepted.
    always_comb begin
        conv_d  = ACCW'(signed'(i_conv_bias));
        pix_ext = '0;
        cw_ext  = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                pix_ext = ACCW'(signed'({1'b0, win_d[r][c]}));
                cw_ext  = ACCW'(signed'(i_conv_weight[(r*K+c)*DW +: DW]));
                conv_d  = conv_d + pix_ext * cw_ext;
            end
        end
`ifdef CONV_RELU_EN
        conv_act = conv_d[ACCW-1] ? '0 : conv_d;
`else
        conv_act = conv_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        col_d   = col_q;
        row_d   = row_q;
        clear   = 1'b0;
        if (xfer) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(IMG_W - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        case (state_q)
            S_FILL: begin
                if (xfer && last_pix) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Second drain cycle: stage 2 has retired the last position.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (i_res_ready) begin
                    state_d = S_FILL;
                    clear   = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        for (int n = 0; n < NCLS; n++) begin
            fcw_ext[n] = ACCW'(signed'(i_fc_weight[(int'(pos_q) * NCLS + n) * DW +: DW]));
            if (clear) begin
                acc_d[n] = '0;
            end else if (tok1_q) begin
                acc_d[n] = acc_q[n] + conv_q * fcw_ext[n];
            end else begin
                acc_d[n] = acc_q[n];
            end
        end
    end

    always_comb begin
        o_res = '0;
        for (int n = 0; n < NCLS; n++) begin
            o_res[n*ACCW +: ACCW] = res_q[n];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FILL;
            drain_q     <= 1'b0;
            pix_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            pix_ready_q <= (state_d == S_FILL);
            res_valid_q <= (state_d == S_OUT);
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < K - 1; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    lb_q[r][c] <= '0;
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            conv_q <= '0;
            pos_q  <= '0;
            tok1_q <= 1'b0;
            for (int n = 0; n < NCLS; n++) begin
                acc_q[n] <= '0;
                res_q[n] <= '0;
            end
        end else begin
            tok1_q <= xfer && in_win;
            if (xfer) begin
                win_q <= win_d;
                for (int r = 0; r < K - 2; r++) begin
                    lb_q[r][col_q] <= lb_q[r+1][col_q];
                end
                lb_q[K-2][col_q] <= i_pix;
                if (in_win) begin
                    conv_q <= conv_act;
                    pos_q  <= pos_d;
                end
            end
            for (int n = 0; n < NCLS; n++) begin
                acc_q[n] <= acc_d[n];
                if (state_q == S_DRAIN && drain_q) begin
                    res_q[n] <= acc_q[n] + ACCW'(signed'(i_fc_bias[n*DW +: DW]));
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_fc_stream_acc.sv
// Randomized and directed bench for conv_fc_stream_acc against a loop-based reference model.
module tb_conv_fc_stream_acc;

    localparam int IMG_W = 28;
    localparam int K     = 3;
    localparam int NCLS  = 10;
    localparam int DW    = 8;
    localparam int ACCW  = 32;
    localparam int OW    = IMG_W - K + 1;
    localparam int NPOS  = OW * OW;
    localparam int NPIX  = IMG_W * IMG_W;

    logic                          i_clk = 1'b0;
    logic                          i_rst_n;
    logic                          i_pix_valid;
    logic                          o_pix_ready;
    logic [DW-1:0]                 i_pix;
    logic [K*K*DW-1:0]             i_conv_weight;
    logic [DW-1:0]                 i_conv_bias;
    logic [NPOS*NCLS*DW-1:0]       i_fc_weight;
    logic [NCLS*DW-1:0]            i_fc_bias;
    logic                          o_res_valid;
    logic                          i_res_ready;
    logic [NCLS*ACCW-1:0]          o_res;

    conv_fc_stream_acc #(
        .IMG_W(IMG_W), .K(K), .NCLS(NCLS), .DW(DW), .ACCW(ACCW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .i_pix        (i_pix),
        .i_conv_weight(i_conv_weight),
        .i_conv_bias  (i_conv_bias),
        .i_fc_weight  (i_fc_weight),
        .i_fc_bias    (i_fc_bias),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_res        (o_res)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    int img [NPIX];
    int cw  [K*K];
    int cb;
    int fw  [NPOS*NCLS];
    int fb  [NCLS];
    int exp_res [NCLS];

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < K*K; i++) i_conv_weight[i*DW +: DW] = cw[i][DW-1:0];
        i_conv_bias = cb[DW-1:0];
        for (int i = 0; i < NPOS*NCLS; i++) i_fc_weight[i*DW +: DW] = fw[i][DW-1:0];
        for (int n = 0; n < NCLS; n++) i_fc_bias[n*DW +: DW] = fb[n][DW-1:0];
    endtask

    // Plain-arithmetic reference: valid conv over the whole image, then dense FC (32-bit wrap).
    task automatic compute_expected();
        int s;
        for (int n = 0; n < NCLS; n++) exp_res[n] = 0;
        for (int orow = 0; orow < OW; orow++) begin
            for (int oc = 0; oc < OW; oc++) begin
                s = cb;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        s += cw[r*K+c] * img[(orow+r)*IMG_W + oc + c];
`ifdef CONV_RELU_EN
                if (s < 0) s = 0;
`endif
                for (int n = 0; n < NCLS; n++)
                    exp_res[n] += s * fw[(orow*OW + oc)*NCLS + n];
            end
        end
        for (int n = 0; n < NCLS; n++) exp_res[n] += fb[n];
    endtask

    task automatic set_ones(input int wval);
        for (int i = 0; i < NPIX; i++) img[i] = 1;
        for (int i = 0; i < K*K; i++) cw[i] = wval;
        cb = 0;
        for (int i = 0; i < NPOS*NCLS; i++) fw[i] = ((i % NCLS) == 0) ? 1 : 0;
        for (int n = 0; n < NCLS; n++) fb[n] = 0;
        apply_cfg();
    endtask

    task automatic set_random();
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
        for (int i = 0; i < K*K; i++) cw[i] = int'($urandom_range(255)) - 128;
        cb = int'($urandom_range(255)) - 128;
        for (int i = 0; i < NPOS*NCLS; i++) fw[i] = int'($urandom_range(255)) - 128;
        for (int n = 0; n < NCLS; n++) fb[n] = int'($urandom_range(255)) - 128;
        apply_cfg();
    endtask

    // gap_mode: 0 none, 1 alternate valid 1-0-1, 2 random ~30% idle.
    task automatic send_frame(input int gap_mode, input int npix);
        logic spurious;
        logic done;
        logic tog;
        int   waits;
        spurious = 1'b0;
        tog      = 1'b0;
        for (int p = 0; p < npix; p++) begin
            done  = 1'b0;
            waits = 0;
            while (!done) begin
                @(negedge i_clk);
                if (o_res_valid) spurious = 1'b1;
                tog = ~tog;
                if ((gap_mode == 1 && !tog) || (gap_mode == 2 && $urandom_range(99) < 30)) begin
                    i_pix_valid = 1'b0;
                end else begin
                    i_pix_valid = 1'b1;
                    i_pix       = img[p][DW-1:0];
                    if (o_pix_ready) done = 1'b1;
                end
                waits++;
                if (!done && waits > 100) begin
                    check_val("pix_ready_timeout", 0, 1);
                    finish_run();
                end
            end
        end
        @(negedge i_clk);
        i_pix_valid = 1'b0;
        check_val("no_early_valid", spurious, 0);
        if (npix == NPIX) begin
            check_val("drain_lat1", {o_res_valid, o_pix_ready}, 2'b00);
        end
    endtask

    task automatic recv_result(input int hold);
        logic [NCLS*ACCW-1:0] snap;
        int w;
        @(negedge i_clk);
        check_val("drain_lat2", {o_res_valid, o_pix_ready}, 2'b00);
        @(negedge i_clk);
        check_val("res_valid_lat3", o_res_valid, 1);
        w = 0;
        while (!o_res_valid && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        snap = o_res;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check_val("hold_stable", {o_res == snap, o_res_valid, o_pix_ready}, 3'b110);
        end
        i_res_ready = 1'b1;
        for (int n = 0; n < NCLS; n++)
            check_val($sformatf("res[%0d]", n), $signed(o_res[n*ACCW +: ACCW]), exp_res[n]);
        @(negedge i_clk);
        i_res_ready = 1'b0;
        check_val("after_handshake", {o_res_valid, o_pix_ready}, 2'b01);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_pix_valid = 1'b0;
        i_res_ready = 1'b0;
        #1;
        check_val("rst_state", {o_res_valid, o_pix_ready, o_res == '0}, 3'b001);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_val("ready_after_rst", {o_pix_ready, o_res_valid}, 2'b10);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_pix_valid   = 1'b0;
        i_pix         = '0;
        i_res_ready   = 1'b0;
        i_conv_weight = '0;
        i_conv_bias   = '0;
        i_fc_weight   = '0;
        i_fc_bias     = '0;
        repeat (3) @(negedge i_clk);
        check_val("reset_outputs", {o_res_valid, o_pix_ready, o_res == '0}, 3'b001);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_val("ready_first_edge", o_pix_ready, 1);

        // All-ones frame, class 0 only.
        set_ones(1);
        for (int n = 0; n < NCLS; n++) exp_res[n] = 0;
        exp_res[0] = 6084;
        send_frame(0, NPIX);
        recv_result(0);

        // Negative kernel: ReLU build clamps, plain build passes through.
        set_ones(-1);
        for (int n = 0; n < NCLS; n++) exp_res[n] = 0;
`ifdef CONV_RELU_EN
        exp_res[0] = 0;
`else
        exp_res[0] = -6084;
`endif
        send_frame(0, NPIX);
        recv_result(0);

        // Valid toggling plus a class-3 bias.
        set_ones(1);
        fb[3] = 5;
        apply_cfg();
        for (int n = 0; n < NCLS; n++) exp_res[n] = 0;
        exp_res[0] = 6084;
        exp_res[3] = 5;
        send_frame(1, NPIX);
        recv_result(0);

        // Back-pressure for 5 cycles, then two back-to-back frames.
        set_ones(1);
        for (int n = 0; n < NCLS; n++) exp_res[n] = 0;
        exp_res[0] = 6084;
        send_frame(0, NPIX);
        recv_result(5);
        send_frame(0, NPIX);
        recv_result(5);

        // Reset mid-frame, then a clean frame.
        send_frame(0, 300);
        do_reset();
        send_frame(0, NPIX);
        recv_result(1);

        // Reset while results are presented.
        send_frame(0, NPIX);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_val("rst_in_out", {o_res_valid, o_pix_ready, o_res == '0}, 3'b001);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_val("ready_after_out_rst", {o_pix_ready, o_res_valid}, 2'b10);
        send_frame(0, NPIX);
        recv_result(0);

        // Random frames against the reference model.
        for (int f = 0; f < 4; f++) begin
            set_random();
            compute_expected();
            send_frame(2, NPIX);
            recv_result(int'($urandom_range(3)));
        end

        finish_run();
    end

endmodule

// File: doc/conv_fc_stream_acc.md
CONV_FC_STREAM_ACC -- requirements
Module: conv_fc_stream_acc

Interface
REQ-001 SHALL have parameter IMG_W, default 28: input image width and height, in pixels.
REQ-002 SHALL have parameter K, default 3: square conv kernel size; OW = IMG_W-K+1 (26), NPOS = OW*OW (676).
REQ-003 SHALL have parameter NCLS, default 10: number of FC output classes.
REQ-004 SHALL have parameter DW, default 8: pixel and weight width.
REQ-005 SHALL have parameter ACCW, default 32: conv and FC accumulator width.
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 i_pix_valid  in  1  pixel stream valid.
REQ-009 o_pix_ready  out  1  pixel stream ready.
REQ-010 i_pix  in  DW  unsigned pixel, raster order, row 0 col 0 first.
REQ-011 i_conv_weight  in  K*K x DW  signed kernel, index r*K+c; held static per frame.
REQ-012 i_conv_bias  in  DW  signed conv bias.
REQ-013 i_fc_weight  in  NPOS x NCLS x DW  signed FC weights, position index or*OW+oc.
REQ-014 i_fc_bias  in  NCLS x DW  signed FC bias.
REQ-015 o_res_valid  out  1  result valid.
REQ-016 i_res_ready  in  1  result ready.
REQ-017 o_res  out  NCLS x ACCW  signed class scores.

Function
REQ-018 A pixel transfer SHALL occur only on a cycle with i_pix_valid=1 and o_pix_ready=1.
REQ-019 Column and row counters SHALL advance per transfer; column wraps IMG_W-1->0 and increments row; row wraps IMG_W-1->0 at frame end.
REQ-020 A (K-1)-row line buffer plus a KxK window register SHALL supply the window ending at each accepted pixel.
REQ-021 For each accepted pixel with row>=K-1 and col>=K-1, stage 1 SHALL register conv = bias + sum(w*pix), sign-extended to ACCW, one cycle after the transfer.
REQ-022 Stage 2 SHALL add conv*i_fc_weight[pos][n], truncated to ACCW, into acc[n] for all n one cycle after stage 1; accumulation wraps modulo 2^ACCW.
REQ-023 Pixel-valid gaps SHALL not change results; pipeline stages advance only when carrying a valid token.
REQ-024 FSM states: S_FILL (o_pix_ready=1), S_DRAIN (o_pix_ready=0, two cycles), S_OUT (o_pix_ready=0, o_res_valid=1).
REQ-025 S_FILL->S_DRAIN SHALL occur on the transfer of pixel (IMG_W-1, IMG_W-1).
REQ-026 S_DRAIN->S_OUT after stage 2 retires the last position; o_res[n] = acc[n] + sign-extended i_fc_bias[n], registered; o_res_valid rises 3 cycles after the last transfer.
REQ-027 In S_OUT, o_res and o_res_valid SHALL hold stable until i_res_ready=1.
REQ-028 On the S_OUT handshake, the FSM SHALL go to S_FILL with accumulators and counters cleared; the next pixel transfer may occur the following cycle.
REQ-029 o_res_valid SHALL be a register output; o_pix_ready SHALL decode from state only, never from i_res_ready.

Reset
REQ-030 While i_rst_n=0: state S_FILL, counters 0, line buffer/window/pipeline tokens cleared, acc 0, o_res 0, o_res_valid 0, o_pix_ready 0.
REQ-031 o_pix_ready SHALL be 1 from the first clock edge after deassertion.
REQ-032 Reset mid-frame or mid-S_OUT SHALL discard all partial results; no stale o_res_valid after release.

Configuration
REQ-033 Macro CONV_RELU_EN: when defined, stage-1 conv results below 0 SHALL be clamped to 0 before FC; when undefined, signed conv results pass unchanged.

Verification
REQ-034 All pixels 1, conv weights 1, conv bias 0, fc_weight[*][0]=1, others 0, fc bias 0 -> o_res[0]=6084, o_res[1..9]=0.
REQ-035 Same as REQ-034 with conv weights -1 -> o_res[0]=0 with CONV_RELU_EN, -6084 without.
REQ-036 REQ-034 stimulus with i_pix_valid toggling 1-0-1 and fc_bias[3]=5 -> o_res[0]=6084, o_res[3]=5; o_res_valid exactly 3 cycles after the last transfer.
REQ-037 Hold i_res_ready=0 for 5 cycles in S_OUT -> o_res stable, o_pix_ready=0; handshake on cycle 6, two back-to-back frames both give 6084.
REQ-038 Assert i_rst_n=0 after pixel 300, then send a full REQ-034 frame -> single o_res[0]=6084, no earlier valid.
